mult_sequencer: RTL

Control sequencer for the 8-bit add-shift signed multiplier datapath (X/A/B registers, 9-bit adder/subtractor). Decodes the synchronized ClearA_LoadB and Execute button levels into per-cycle datapath strobes. It runs WIDTH-1 add/shift steps and one final subtract/shift step, then holds until Execute is released. Sits between the button synchronizers and the register unit/adder in the processor top level.

---
 rtl/mult_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mult_sequencer.sv
// Control sequencer for the add-shift signed multiplier: turns button levels into datapath strobes.
// Optional MULT_SKIP_ADD_EN: a zero multiplier bit folds its add/sub step into the shift.
module mult_sequencer #(
    parameter int WIDTH = 8,
    localparam int IW = $clog2(WIDTH)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Execute,
    input  logic          ClearA_LoadB,
    input  logic          M,
    output logic          Clr_XA,
    output logic          Ld_B,
    output logic          Add,
    output logic          Sub,
    output logic          Ld_XA,
    output logic          Shift_En,
    output logic          Busy,
    output logic          Done,
    output logic [IW-1:0] Iter
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_ADD,
        S_SHIFT,
        S_SUB,
        S_DONE
    } state_t;

    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] iter_q, iter_d;
    logic [IW-1:0] iter_inc;
    logic          shift_step;
    logic          clr_c, ldb_c, add_c, sub_c, ldxa_c, shen_c, done_c;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    assign iter_inc = iter_q + IW'(1);

    always_comb begin
        state_d    = state_q;
        iter_d     = iter_q;
        shift_step = 1'b0;
        clr_c      = 1'b0;
        ldb_c      = 1'b0;
        add_c      = 1'b0;
        sub_c      = 1'b0;
        ldxa_c     = 1'b0;
        shen_c     = 1'b0;
        done_c     = 1'b0;
        case (state_q)
            S_IDLE: begin
                iter_d = '0;
                if (Execute) begin
                    state_d = S_CLR;
                end else if (ClearA_LoadB) begin
                    clr_c = 1'b1;
                    ldb_c = 1'b1;
                end
            end
            S_CLR: begin
                clr_c   = 1'b1;
                iter_d  = '0;
                state_d = S_ADD;
            end
            S_ADD: begin
                add_c   = M;
                ldxa_c  = M;
                state_d = S_SHIFT;
`ifdef MULT_SKIP_ADD_EN
                shift_step = !M;
`endif
            end
            S_SUB: begin
                sub_c   = M;
                ldxa_c  = M;
                state_d = S_SHIFT;
`ifdef MULT_SKIP_ADD_EN
                shift_step = !M;
`endif
            end
            S_SHIFT: shift_step = 1'b1;
            S_DONE: begin
                done_c = 1'b1;
                if (!Execute) begin
                    state_d = S_IDLE;
                    iter_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Shared shift handling; a bypassed zero-bit step lands here from ADD/SUB.
        if (shift_step) begin
            shen_c = 1'b1;
            if (iter_q == LAST) begin
                state_d = S_DONE;
            end else begin
                iter_d  = iter_inc;
                state_d = (iter_inc == LAST) ? S_SUB : S_ADD;
            end
        end
    end

    // Reset also masks the input-driven IDLE strobes so nothing leaks out while held.
    assign Clr_XA   = clr_c & Reset;
    assign Ld_B     = ldb_c & Reset;
    assign Add      = add_c & Reset;
    assign Sub      = sub_c & Reset;
    assign Ld_XA    = ldxa_c & Reset;
    assign Shift_En = shen_c & Reset;
    assign Done     = done_c & Reset;
    assign Busy     = Reset & (state_q != S_IDLE) & (state_q != S_DONE);
    assign Iter     = iter_q;

endmodule
